booth_iter_mul: RTL and testbench

- Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
- Sits in the execute stage. Generates one Booth partial product per cycle and feeds it, with the carry-save accumulator, into a 35-bit carry-save adder row.
- A final carry-propagate add resolves the product.
- Valid/ready handshakes on both sides. A flush input lets the fast-interrupt path abort an in-flight multiply.

---
 rtl/booth_iter_mul_pkg.sv | 35 +++
 rtl/booth_pp_gen.sv | 34 +++
 rtl/csa35.sv | 15 +
 rtl/booth_iter_mul.sv | 160 ++++++++++++++++
 tb/tb_booth_iter_mul.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/booth_iter_mul_pkg.sv
// Shared encodings for the iterative radix-4 Booth multiplier: op codes, FSM states,
// Booth digit patterns and the constant that removes the partial-product bias.
package booth_iter_mul_pkg;

   localparam int ITER  = 17;
   localparam int EXT_W = 35;

   // Each of the ITER partial products carries +2^34 so the carry-save pair stays
   // non-negative and shifts logically; their sum, seen from bit 32, is 0x5_5555_5554.
   localparam logic [31:0] HI_BIAS_FIX = 32'hAAAA_AAAC;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [2:0] BD_Z0  = 3'b000;
   localparam logic [2:0] BD_P1A = 3'b001;
   localparam logic [2:0] BD_P1B = 3'b010;
   localparam logic [2:0] BD_P2  = 3'b011;
   localparam logic [2:0] BD_M2  = 3'b100;
   localparam logic [2:0] BD_M1A = 3'b101;
   localparam logic [2:0] BD_M1B = 3'b110;
   localparam logic [2:0] BD_Z1  = 3'b111;

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: one-complemented magnitude for negative
// digits, with the missing +1 reported on neg.
module booth_pp_gen
   import booth_iter_mul_pkg::*;
(
   input  logic [2:0]       digit,
   input  logic [EXT_W-1:0] mcand,
   output logic [EXT_W-1:0] pp,
   output logic             neg
);

   logic [EXT_W-1:0] mag;

   always_comb begin
      mag = '0;
      neg = 1'b0;
      case (digit)
         BD_Z0, BD_Z1:   mag = '0;
         BD_P1A, BD_P1B: mag = mcand;
         BD_P2:          mag = {mcand[EXT_W-2:0], 1'b0};
         BD_M2: begin
            mag = {mcand[EXT_W-2:0], 1'b0};
            neg = 1'b1;
         end
         BD_M1A, BD_M1B: begin
            mag = mcand;
            neg = 1'b1;
         end
         default:        mag = '0;
      endcase
      pp = neg ? ~mag : mag;
   end

endmodule

// File: rtl/csa35.sv
// 35-bit carry-save adder row: three operands in, sum and (unshifted) carry vectors out.
module csa35
   import booth_iter_mul_pkg::*;
(
   input  logic [EXT_W-1:0] ain,
   input  logic [EXT_W-1:0] bin,
   input  logic [EXT_W-1:0] cin,
   output logic [EXT_W-1:0] sum,
   output logic [EXT_W-1:0] carry
);

   assign sum   = ain ^ bin ^ cin;
   assign carry = (ain & bin) | (ain & cin) | (bin & cin);

endmodule

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU: one Booth digit
// per cycle into a carry-save accumulator, low product bits retired two per cycle.
module booth_iter_mul
   import booth_iter_mul_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [EXT_W-1:0]  m_q, m_d;
   logic [EXT_W-1:0]  y_q, y_d;
   logic [EXT_W-1:0]  s_q, s_d;
   logic [EXT_W-1:0]  c_q, c_d;
   logic [XLEN-1:0]   l_q, l_d;
   logic              lc_q, lc_d;
   logic [4:0]        count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [EXT_W-1:0]  pp, pp_b, csa_s, csa_c;
   logic              pp_neg;
   logic [2:0]        low;
   logic [XLEN-1:0]   hi;
   logic              signed_a, signed_b;

   booth_pp_gen u_pp_gen (
      .digit (y_q[2:0]),
      .mcand (m_q),
      .pp    (pp),
      .neg   (pp_neg)
   );

   // Flipping bit 34 adds 2^34, making every partial product non-negative.
   assign pp_b = {~pp[EXT_W-1], pp[EXT_W-2:0]};

   csa35 u_csa (
      .ain   (s_q),
      .bin   (c_q),
      .cin   (pp_b),
      .sum   (csa_s),
      .carry (csa_c)
   );

   // Carry vector is {csa_c, pp_neg}; its two low bits join the sum's two low bits here.
   assign low = {1'b0, csa_s[1:0]} + {1'b0, csa_c[0], pp_neg} + {2'b00, lc_q};
   assign hi  = s_q[XLEN-1:0] + c_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, lc_q} + HI_BIAS_FIX;

   assign signed_a = (op != OP_MUL) && (op != OP_MULHU);
   assign signed_b = (op == OP_MULH);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      m_d         = m_q;
      y_d         = y_q;
      s_d         = s_q;
      c_d         = c_q;
      l_d         = l_q;
      lc_d        = lc_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d    = op;
               m_d     = {{3{signed_a & rs1[XLEN-1]}}, rs1};
               y_d     = {{2{signed_b & rs2[XLEN-1]}}, rs2, 1'b0};
               s_d     = '0;
               c_d     = '0;
               l_d     = '0;
               lc_d    = 1'b0;
               count_d = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            y_d     = {2'b00, y_q[EXT_W-1:2]};
            count_d = count_q + 5'd1;
            if (count_q == 5'(ITER - 1)) begin
               // Last digit is left unshifted so S+C+lc sits exactly at bit 32.
               s_d     = csa_s;
               c_d     = {csa_c[EXT_W-2:0], pp_neg};
               state_d = ST_FINAL;
            end else begin
               s_d  = {2'b00, csa_s[EXT_W-1:2]};
               c_d  = {1'b0, csa_c[EXT_W-1:1]};
               l_d  = {low[1:0], l_q[XLEN-1:2]};
               lc_d = low[2];
            end
         end
         ST_FINAL: begin
            result_d    = (op_q == OP_MUL) ? l_q : hi;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         m_q         <= '0;
         y_q         <= '0;
         s_q         <= '0;
         c_q         <= '0;
         l_q         <= '0;
         lc_q        <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         m_q         <= m_d;
         y_q         <= y_d;
         s_q         <= s_d;
         c_q         <= c_d;
         l_q         <= l_d;
         lc_q        <= lc_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_booth_iter_mul.sv
// Self-checking bench for booth_iter_mul: directed corner cases, handshake/flush/reset
// behaviour, and random operations against a 64-bit arithmetic reference.
module tb_booth_iter_mul;
   import booth_iter_mul_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   booth_iter_mul #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rs1       (rs1),
      .rs2       (rs2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (o == OP_MULH || o == OP_MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (o == OP_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (o == OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Called just after an accepting edge; counts edges until out_valid, bounded.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input string tag);
      int lat;
      @(negedge clk);
      check_eq({tag, "_in_ready"}, in_ready, 1'b1);
      op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      wait_valid(lat);
      check_eq({tag, "_lat"}, lat, 18);
      check_eq({tag, "_res"}, result, exp);
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk); #1; end
         check_eq({tag, "_hold"}, {out_valid, result}, {1'b1, exp});
      end
      handshake();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic seen;
      logic [1:0] o;
      logic [31:0] a, b;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_result", result, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_m3");
      run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
      run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mul_m1");
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
      run_op(OP_MULHSU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 0, "mulhsu_max");
      run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_m1");
      run_op(OP_MULH,   32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_zero");
      run_op(OP_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 0, "mulhu_carry");

      // Backpressure: in_valid stays high throughout and must be ignored until IDLE.
      @(negedge clk); op = OP_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(posedge clk); #1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5;
      wait_valid(lat);
      check_eq("bp_lat", lat, 18);
      repeat (5) begin
         @(posedge clk); #1;
         check_eq("bp_hold", {in_ready, out_valid, result}, {1'b0, 1'b1, 32'hFFFF_FFFE});
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check_eq("bp_release", {in_ready, out_valid, busy}, 3'b100);
      @(posedge clk); #1; in_valid = 1'b0;
      check_eq("bp_next_accept", {in_ready, busy}, 2'b01);
      wait_valid(lat);
      check_eq("bp_next_lat", lat, 18);
      check_eq("bp_next_res", result, 32'h0000_000F);
      handshake();

      // Flush in the middle of CALC (count 8).
      @(negedge clk); op = OP_MUL; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check_eq("flush_idle", {in_ready, busy, out_valid}, 3'b100);
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check_eq("flush_no_result", seen, 1'b0);

      @(negedge clk); op = OP_MUL; rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
      check_eq("flush_blocks_accept", {in_ready, busy}, 2'b10);
      run_op(OP_MUL, 32'd3, 32'd5, 32'h0000_000F, 0, "after_flush");

      // Flush while a result is waiting for out_ready.
      @(negedge clk); op = OP_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      wait_valid(lat);
      check_eq("flush_done_lat", lat, 18);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check_eq("flush_done", {in_ready, out_valid}, 2'b10);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk); op = OP_MULH; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1357_9BDF; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3; rst_n = 1'b0; #1;
      check_eq("areset", {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 1500; i++) begin
         o = 2'($urandom_range(0, 3));
         a = rand_opnd();
         b = rand_opnd();
         run_op(o, a, b, ref_mul(o, a, b), $urandom_range(0, 2), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
